aes_result_buffer: RTL

//  Downstream consumer of the AES round pipeline: captures each completed result (out, out_type) and queues it in a FIFO.

---
 rtl/aes_result_buffer_pkg.sv | 17 +
 rtl/aes_result_buffer_credit_ctr.sv | 64 ++++++
 rtl/aes_result_buffer.sv | 91 +++++++++
 3 files changed

// File: rtl/aes_result_buffer_pkg.sv
// Shared types and defaults for the AES result buffer.
package aes_result_buffer_pkg;

   typedef enum logic [1:0] {
      INVALID = 2'd0,
      ENCRYPT = 2'd1,
      DECRYPT = 2'd2
   } job_t;

   localparam int AES_BLOCK_W      = 128;
   localparam int RESULT_BUF_DEPTH = 4;

   function automatic logic is_job(input logic [1:0] t);
      return (t == ENCRYPT) || (t == DECRYPT);
   endfunction

endpackage

// File: rtl/aes_result_buffer_credit_ctr.sv
// Credit/occupancy accounting and protocol error detection
// for the AES result buffer.
module aes_credit_ctr
   import aes_result_buffer_pkg::*;
#(
   parameter int  DEPTH = RESULT_BUF_DEPTH,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          issue_i,
   input  logic          push_req,
   input  logic          bad_type,
   input  logic          pop,
   output logic          issue_ok,
   output logic          push,
   output logic [CW-1:0] count,
   output logic [CW-1:0] inflight,
   output logic          err_sticky
);

   localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic          err_q, err_d;
   logic [CW:0]   used_w;
   logic          full, iss, no_job;

   // Slots reserved = stored results plus jobs still in the pipeline.
   assign used_w   = {1'b0, count_q} + {1'b0, inflight_q};
   assign issue_ok = used_w < DEPTH_W;
   assign full     = count_q == DEPTH_C;
   assign no_job   = inflight_q == '0;
   assign iss      = issue_i & issue_ok;
   assign push     = push_req & ~no_job & (~full | pop);

   always_comb begin
      count_d    = count_q + CW'(push) - CW'(pop);
      inflight_d = inflight_q + CW'(iss) - CW'(push);
      err_d      = err_q
                 | (issue_i & ~issue_ok)
                 | (push_req & (no_job | (full & ~pop)))
                 | bad_type;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= '0;
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         count_q    <= count_d;
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end

   assign count      = count_q;
   assign inflight   = inflight_q;
   assign err_sticky = err_q;

endmodule

// File: rtl/aes_result_buffer.sv
// Credit-managed FIFO of AES pipeline results with a registered
// first-word-fall-through head presented to the host.
module aes_result_buffer
   import aes_result_buffer_pkg::*;
#(
   parameter int  DEPTH  = RESULT_BUF_DEPTH,
   parameter int  DATA_W = AES_BLOCK_W,
   localparam int CW     = $clog2(DEPTH + 1),
   localparam int PW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_i,
   input  logic [DATA_W-1:0] in_data,
   input  job_t              in_type,
   output logic              issue_ok,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output job_t              out_type,
   output logic [CW-1:0]     count,
   output logic [CW-1:0]     inflight,
   output logic              err_sticky
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   job_t              tmem_q [DEPTH];
   logic [PW-1:0]     wr_q, rd_q, rd_nx;
   logic [DATA_W-1:0] head_data_q, head_data_d;
   job_t              head_type_q, head_type_d;
   logic              push_req, bad_type, push, pop;

   assign push_req  = is_job(in_type);
   assign bad_type  = (in_type != INVALID) & ~push_req;
   assign out_valid = count != '0;
   assign pop       = out_valid & out_ready;
   assign rd_nx     = rd_q + PW'(pop);

   aes_credit_ctr #(.DEPTH(DEPTH)) u_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .issue_i    (issue_i),
      .push_req   (push_req),
      .bad_type   (bad_type),
      .pop        (pop),
      .issue_ok   (issue_ok),
      .push       (push),
      .count      (count),
      .inflight   (inflight),
      .err_sticky (err_sticky)
   );

   // Head register: an arrival into an (effectively) empty queue
   // bypasses storage; otherwise a pop loads the next stored entry.
   always_comb begin
      head_data_d = head_data_q;
      head_type_d = head_type_q;
      if (push && count == CW'(pop)) begin
         head_data_d = in_data;
         head_type_d = in_type;
      end else if (pop && count != CW'(1)) begin
         head_data_d = mem_q[rd_nx];
         head_type_d = tmem_q[rd_nx];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_q]  <= in_data;
         tmem_q[wr_q] <= in_type;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q        <= '0;
         rd_q        <= '0;
         head_data_q <= '0;
         head_type_q <= INVALID;
      end else begin
         wr_q        <= wr_q + PW'(push);
         rd_q        <= rd_nx;
         head_data_q <= head_data_d;
         head_type_q <= head_type_d;
      end
   end

   assign out_data = head_data_q;
   assign out_type = out_valid ? head_type_q : INVALID;

endmodule
